booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width of the shared Booth core (product width 2*WIDTH).
REQ-002 SHALL have parameter: TIMEOUT, 32, maximum cycles in RUN before abort (used only with BOOTH_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: reqN_valid in 1, reqN_a in WIDTH, reqN_b in WIDTH, reqN_ready out 1, for N=0,1 (request channels, signed operands).
REQ-006 SHALL have ports: rspN_valid out 1, rspN_prod out 2*WIDTH, rspN_err out 1, rspN_ready in 1, for N=0,1 (response channels).
REQ-007 SHALL have ports: mul_en out 1, mul_a out WIDTH, mul_b out WIDTH (core controls), mul_prod in 2*WIDTH, mul_done in 1 (core status).
REQ-008 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, CLEAR, RUN, RESP.
REQ-010 IDLE: SHALL assert reqN_ready only for the selected requester; when none are valid, no ready is asserted.
REQ-011 Selection: if exactly one reqN_valid is high, SHALL select it; if both are high, SHALL select the requester not granted last (round-robin); last_grant resets to 1, so req0 wins the first tie.
REQ-012 On handshake (reqN_valid & reqN_ready), SHALL register the operands into mul_a/mul_b, record the owner, update last_grant, and go to CLEAR.
REQ-013 CLEAR: SHALL hold mul_en low for exactly one cycle to restart the core, then go to RUN.
REQ-014 RUN: SHALL hold mul_en high and mul_a/mul_b stable until mul_done is sampled high.
REQ-015 On the first RUN cycle with mul_done high, SHALL capture mul_prod into the owner's rsp_prod, drop mul_en, and go to RESP.
REQ-016 RESP: SHALL assert the owner's rsp_valid with prod and err stable until the owner's rsp_ready is high, then return to IDLE.
REQ-017 Only the owner's rsp_valid SHALL ever be high, and at most one response is outstanding at a time.
REQ-018 A new request SHALL NOT be accepted in the cycle rsp_ready completes a response; the earliest acceptance is the following cycle (IDLE).
REQ-019 SHALL leave request validity unchecked outside IDLE: held requests simply wait, and none are dropped or reordered per channel.
REQ-020 Latency: accept at cycle T, CLEAR at T+1, RUN from T+2; rsp_valid rises the cycle after mul_done is sampled.
REQ-021 mul_done seen outside RUN SHALL be ignored.

Reset
REQ-022 While rst_n is low, SHALL force state IDLE, last_grant=1, and all outputs 0 (reqN_ready, rspN_valid, rspN_prod, rspN_err, mul_en, mul_a, mul_b, busy).
REQ-023 Reset asserted mid-operation SHALL abort immediately, discarding the in-flight operation with no response issued; mul_en falls asynchronously.
REQ-024 After reset release, the first acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-025 Macro BOOTH_ARB_TIMEOUT_EN defined: SHALL count RUN cycles; at TIMEOUT cycles without mul_done, SHALL drop mul_en and go to RESP with prod=0 and err=1.
REQ-026 Macro BOOTH_ARB_TIMEOUT_EN undefined: SHALL omit the counter, wait in RUN indefinitely, and tie rspN_err to 0.

Verification
REQ-027 Reset, then req0 a=3, b=5 -> req0_ready in IDLE, mul_en low one cycle then high; rsp0_valid with rsp0_prod=0x0F, err=0.
REQ-028 req1 a=-3 (0xD), b=5 -> rsp1_prod=0xF1; a=-8, b=-8 -> rsp1_prod=0x40.
REQ-029 Both valid on the first cycle after reset (req0 2x2, req1 7x7) -> req0 served first (0x04), then req1 (0x31); a repeated tie alternates grant.
REQ-030 Hold rsp0_ready low for 10 cycles -> rsp0_valid/prod stable, req1_ready stays low, and no core activity.
REQ-031 Assert rst_n low during RUN -> all outputs 0 immediately and no response after release; the next request completes correctly.
REQ-032 With BOOTH_ARB_TIMEOUT_EN, mul_done tied 0 -> rsp0_valid after 32 RUN cycles with prod=0x00 and err=1; without the macro, busy stays high.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : booth_mul_arbiter                                           |
// | Description: Round-robin front end sharing one signed Booth multiplier   |
// |              core between two request/response channels.                |
// |              Optional RUN watchdog: define BOOTH_ARB_TIMEOUT_EN.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module booth_mul_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // request channels
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    // response channels
    output logic                 rsp0_valid,
    output logic [2*WIDTH-1:0]   rsp0_prod,
    output logic                 rsp0_err,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    output logic [2*WIDTH-1:0]   rsp1_prod,
    output logic                 rsp1_err,
    input  logic                 rsp1_ready,
    // shared core
    output logic                 mul_en,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_prod,
    input  logic                 mul_done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               r_owner;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_prod0;
    logic [2*WIDTH-1:0] r_prod1;
    logic               r_err0;
    logic               r_err1;

    logic               w_sel;
    logic               w_any_valid;
    logic               w_idle;
    logic               w_accept;
    logic               w_rsp_ready_owner;
    logic               w_timeout;
    logic               w_finish;
    logic [2*WIDTH-1:0] w_result;

    // Tie-break favours the requester that was not granted last time.
    always_comb begin
        w_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            w_sel = ~r_last_grant;
        end else if (req1_valid) begin
            w_sel = 1'b1;
        end
    end

    // rst_n gating keeps ready low during reset while the state already reads IDLE.
    assign w_any_valid       = req0_valid | req1_valid;
    assign w_idle            = (r_state == S_IDLE) & rst_n;
    assign w_accept          = w_idle & w_any_valid;
    assign w_rsp_ready_owner = r_owner ? rsp1_ready : rsp0_ready;
    assign w_finish          = (r_state == S_RUN) & (mul_done | w_timeout);
    assign w_result          = mul_done ? mul_prod : '0;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_run_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_run_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_RUN) & ~mul_done
                     & (r_run_cnt == c_cnt_w'(TIMEOUT - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        mul_en      = 1'b0;
        busy        = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = w_accept & ~w_sel;
                req1_ready = w_accept &  w_sel;
                if (w_accept) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy        = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                mul_en = 1'b1;
                if (mul_done || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                busy       = 1'b1;
                rsp0_valid = ~r_owner;
                rsp1_valid =  r_owner;
                if (w_rsp_ready_owner) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand, ownership and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_prod0      <= '0;
            r_prod1      <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mul_a      <= w_sel ? req1_a : req0_a;
                r_mul_b      <= w_sel ? req1_b : req0_b;
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
            end
            if (w_finish) begin
                if (r_owner) begin
                    r_prod1 <= w_result;
                    r_err1  <= w_timeout;
                end else begin
                    r_prod0 <= w_result;
                    r_err0  <= w_timeout;
                end
            end
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp0_prod = r_prod0;
    assign rsp1_prod = r_prod1;
    assign rsp0_err  = r_err0;
    assign rsp1_err  = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_booth_mul_arbiter                                        |
// | Description: Self-checking bench for booth_mul_arbiter with an emulated  |
// |              multiplier core and a transaction-level reference model.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_booth_mul_arbiter;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       q_valid [2];
    logic [3:0] q_a     [2];
    logic [3:0] q_b     [2];
    logic       rsp_rdy [2];
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [7:0] rsp0_prod, rsp1_prod;
    logic       mul_en, mul_done, busy;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_prod;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (q_valid[0]),
        .req0_a     (q_a[0]),
        .req0_b     (q_b[0]),
        .req0_ready (req0_ready),
        .req1_valid (q_valid[1]),
        .req1_a     (q_a[1]),
        .req1_b     (q_b[1]),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_prod  (rsp0_prod),
        .rsp0_err   (rsp0_err),
        .rsp0_ready (rsp_rdy[0]),
        .rsp1_valid (rsp1_valid),
        .rsp1_prod  (rsp1_prod),
        .rsp1_err   (rsp1_err),
        .rsp1_ready (rsp_rdy[1]),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_prod   (mul_prod),
        .mul_done   (mul_done),
        .busy       (busy)
    );

    // Reference model: one outstanding transaction, tracked by its age in cycles.
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         m_busy, m_resp, m_resp_seen, m_err;
    int         m_owner, m_age, m_last, m_lat;
    logic [3:0] m_a, m_b;
    logic [7:0] m_exp;
    bit         consumed [2];
    bit         rand_mode  = 0;
    bit         core_stuck = 0;
    int         rdy_mode   = 1;
    int         lat_max    = 5;
    logic [8:0] dir_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        int x;
        int y;
        x = $signed(a);
        y = $signed(b);
        return 8'(x * y);
    endfunction

    function automatic int pick();
        if (q_valid[0] && q_valid[1]) return (m_last == 1) ? 0 : 1;
        if (q_valid[0]) return 0;
        if (q_valid[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_resp_seen = 0; m_err = 0;
        m_age  = 0; m_last = 1; m_owner = 0;
    endtask

    task automatic model_edge(input int sel);
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (m_resp) begin
                if (rsp_rdy[m_owner]) begin
                    m_busy = 0;
                    m_resp = 0;
                end
            end else if (m_age >= 2 && mul_done) begin
                m_resp = 1; m_resp_seen = 0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            end else if (m_age >= 2 && m_age - 2 == TIMEOUT - 1) begin
                m_resp = 1; m_resp_seen = 0; m_exp = 8'h00; m_err = 1;
`endif
            end else begin
                m_age++;
            end
        end else if (sel >= 0) begin
            m_busy  = 1; m_owner = sel; m_age = 1; m_last = sel;
            m_a     = q_a[sel]; m_b = q_b[sel];
            m_exp   = smul(q_a[sel], q_b[sel]);
            m_err   = 0;
            m_lat   = $urandom_range(0, lat_max);
            consumed[sel] = 1;
        end
    endtask

    task automatic drive();
        int sa;
        int sb;
        for (int i = 0; i < 2; i++) begin
            if (consumed[i]) q_valid[i] = 1'b0;
            if (rand_mode && !q_valid[i] && $urandom_range(0, 2) == 0) begin
                q_valid[i] = 1'b1;
                q_a[i]     = 4'($urandom);
                q_b[i]     = 4'($urandom);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rdy_mode == 0)      rsp_rdy[i] = 1'($urandom_range(0, 1));
            else if (rdy_mode == 1) rsp_rdy[i] = 1'b1;
            else                    rsp_rdy[i] = 1'b0;
        end
        // Emulated core: done after m_lat RUN cycles, stray done pulses elsewhere.
        if (core_stuck) begin
            mul_done = 1'b0;
            mul_prod = 8'($urandom);
        end else if (m_busy && !m_resp && m_age >= 2) begin
            if (m_age - 2 >= m_lat) begin
                sa = $signed(mul_a);
                sb = $signed(mul_b);
                mul_done = 1'b1;
                mul_prod = 8'(sa * sb);
            end else begin
                mul_done = 1'b0;
                mul_prod = 8'($urandom);
            end
        end else begin
            mul_done = ($urandom_range(0, 3) == 0);
            mul_prod = 8'($urandom);
        end
    endtask

    task automatic step();
        int         sel;
        logic [8:0] e;
        @(negedge clk);
        sel = pick();
        chk("req0_ready", req0_ready, rst_n && !m_busy && sel == 0);
        chk("req1_ready", req1_ready, rst_n && !m_busy && sel == 1);
        chk("busy", busy, m_busy);
        chk("mul_en", mul_en, m_busy && !m_resp && m_age >= 2);
        chk("rsp0_valid", rsp0_valid, m_resp && m_owner == 0);
        chk("rsp1_valid", rsp1_valid, m_resp && m_owner == 1);
        if (m_busy && !m_resp && m_age >= 1) chk("mul_ab", {mul_a, mul_b}, {m_a, m_b});
        if (m_resp) begin
            chk("rsp_prod", (m_owner == 1) ? rsp1_prod : rsp0_prod, m_exp);
            chk("rsp_err", (m_owner == 1) ? rsp1_err : rsp0_err, m_err);
        end
        if (!rst_n) chk("rst_data", {rsp0_prod, rsp1_prod, mul_a, mul_b}, 0);
        if (m_resp && !m_resp_seen && dir_q.size() > 0) begin
            e = dir_q.pop_front();
            chk("directed_rsp", {rsp1_valid, rsp0_valid, e[8] ? rsp1_prod : rsp0_prod},
                {e[8], !e[8], e[7:0]});
        end
        if (m_resp) m_resp_seen = 1;
        @(posedge clk);
        consumed[0] = 0;
        consumed[1] = 0;
        model_edge(sel);
        #1;
        drive();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((q_valid[0] || q_valid[1] || m_busy) && n < bound) begin
            step();
            n++;
        end
        chk("drain_done", {31'd0, !(q_valid[0] || q_valid[1] || m_busy)}, 1);
    endtask

    task automatic post(input int ch, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        q_valid[ch] = 1'b1;
        q_a[ch]     = a;
        q_b[ch]     = b;
        dir_q.push_back({ch[0], exp});
    endtask

    task automatic chk_zero_now(input string tag);
        chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                           rsp0_err, rsp1_err, mul_en, busy}, 0);
        chk({tag, "_data"}, {rsp0_prod, rsp1_prod, mul_a, mul_b}, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q_valid[i] = 1'b0; q_a[i] = '0; q_b[i] = '0; rsp_rdy[i] = 1'b0;
            consumed[i] = 0;
        end
        mul_done = 1'b0;
        mul_prod = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_zero_now("reset");

        // Tie on the first cycle after reset: req0 first, then req1.
        post(0, 4'd2, 4'd2, 8'h04);
        post(1, 4'd7, 4'd7, 8'h31);
        step();
        step();
        rst_n = 1'b1;
        drain(60);

        // Second tie (last grant was req1), then a lone req1.
        post(0, 4'd3, 4'd5, 8'h0F);
        post(1, 4'hD, 4'd5, 8'hF1);
        drain(60);
        post(1, 4'h8, 4'h8, 8'h40);
        drain(60);

        // Response back-pressure with req1 waiting.
        rdy_mode = 2;
        post(0, 4'd2, 4'd3, 8'h06);
        n = 0;
        while (!m_resp && n < 30) begin step(); n++; end
        chk("hold_reached", {31'd0, m_resp}, 1);
        post(1, 4'd1, 4'd1, 8'h01);
        repeat (10) step();
        rdy_mode = 1;
        drain(60);

        // Reset in the middle of RUN, with req1 held across the reset.
        lat_max = 20;
        q_valid[0] = 1'b1; q_a[0] = 4'd5; q_b[0] = 4'd5;
        n = 0;
        while (!(m_busy && m_age >= 3) && n < 30) begin step(); n++; end
        chk("run_reached", {31'd0, m_busy && m_age >= 3}, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_zero_now("async_reset");
        post(1, 4'd4, 4'd4, 8'h10);
        step();
        rst_n = 1'b1;
        lat_max = 5;
        drain(60);

        // Randomized traffic
        rand_mode = 1;
        rdy_mode  = 0;
        repeat (1500) step();
        rand_mode = 0;
        rdy_mode  = 1;
        drain(200);

        // Core that never completes
        core_stuck = 1;
`ifdef BOOTH_ARB_TIMEOUT_EN
        post(0, 4'd3, 4'd3, 8'h00);
        drain(80);
`else
        q_valid[0] = 1'b1; q_a[0] = 4'd3; q_b[0] = 4'd3;
        repeat (45) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_zero_now("stuck_reset");
        step();
        rst_n = 1'b1;
`endif
        core_stuck = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
